// File: rtl/load_store_core.sv
// Smallest m >= 2 coprime to a sampled 16-bit n, found by subtraction-based Euclid.
// Optional done output enabled by defining LOAD_STORE_DONE_EN.
module load_store_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] read_in,
    output logic [WIDTH-1:0] write_out
`ifdef LOAD_STORE_DONE_EN
    ,
    output logic             done
`endif
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);
    localparam logic [WIDTH-1:0] Two = WIDTH'(2);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGcd,
        StCheck,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                state_d = StLoad;
            end
            StLoad: begin
                n_d = read_in;
                m_d = Two;
                a_d = read_in;
                b_d = Two;
                if (read_in == '0) begin
                    out_d   = '0;
                    state_d = StFin;
                end else begin
                    state_d = StGcd;
                end
            end
            StGcd: begin
                if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else if (b_q > a_q) begin
                    b_d = b_q - a_q;
                end else begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (a_q == One) begin
                    out_d   = m_q;
                    state_d = StFin;
                end else if (m_q == '1) begin
                    // Unreachable for any 16-bit n; guards against m wrapping to 0.
                    out_d   = '0;
                    state_d = StFin;
                end else begin
                    m_d     = m_q + One;
                    a_d     = n_q;
                    b_d     = m_q + One;
                    state_d = StGcd;
                end
            end
            StFin: begin
                state_d = StFin;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign write_out = out_q;

`ifdef LOAD_STORE_DONE_EN
    assign done = (state_q == StFin);
`endif

endmodule

// File: tb/tb_load_store_core.sv
// Directed bench for load_store_core: expected results are hand-computed constants.
// Works with or without LOAD_STORE_DONE_EN defined.
module tb_load_store_core;

    logic        clock;
    logic        rst;
    logic [15:0] read_in;
    logic [15:0] write_out;
`ifdef LOAD_STORE_DONE_EN
    logic        done;
`endif

    int checks;
    int errors;
    int cyc;

    load_store_core #(
        .WIDTH(16)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .read_in  (read_in),
        .write_out(write_out)
`ifdef LOAD_STORE_DONE_EN
        ,
        .done     (done)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag, input logic exp);
`ifdef LOAD_STORE_DONE_EN
        check(tag, {15'b0, done}, {15'b0, exp});
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    // Bounded wait until write_out becomes nonzero; a timeout leaves write_out 0.
    task automatic wait_result(input int limit, output int n);
        n = 0;
        while (write_out == 16'h0 && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        read_in = 16'h13b0;

        // Reset for two cycles, then compute for 5040 -> 11.
        step();
        step();
        check("reset_out", write_out, 16'h0000);
        check_done("reset_done", 1'b0);
        rst = 1'b0;
        repeat (5) step();
        check("5040_busy", write_out, 16'h0000);
        check_done("5040_busy_done", 1'b0);
        wait_result(40000, cyc);
        check("5040_result", write_out, 16'h000b);
        check_done("5040_done", 1'b1);

        // FIN ignores read_in changes.
        read_in = 16'h1234;
        repeat (20) step();
        check("fin_hold", write_out, 16'h000b);
        check_done("fin_hold_done", 1'b1);

        // 4660 -> 3.
        rst = 1'b1;
        step();
        check("rst_clear", write_out, 16'h0000);
        rst = 1'b0;
        wait_result(40000, cyc);
        check("4660_result", write_out, 16'h0003);

        // n=1: exact latency, result on the 5th edge after release.
        rst = 1'b1;
        read_in = 16'h0001;
        step();
        rst = 1'b0;
        repeat (4) step();
        check("n1_before", write_out, 16'h0000);
        step();
        check("n1_result", write_out, 16'h0002);

        // n=7: result on the 8th edge after release.
        rst = 1'b1;
        read_in = 16'h0007;
        step();
        rst = 1'b0;
        repeat (7) step();
        check("n7_before", write_out, 16'h0000);
        check_done("n7_before_done", 1'b0);
        step();
        check("n7_result", write_out, 16'h0002);

        // n=0: straight to FIN with 0 on the 2nd edge after release.
        rst = 1'b1;
        read_in = 16'h0000;
        step();
        rst = 1'b0;
        step();
        check_done("n0_load_done", 1'b0);
        step();
        read_in = 16'h0005;
        repeat (5) step();
        check("n0_result", write_out, 16'h0000);
        check_done("n0_done", 1'b1);

        // Abort mid-GCD, then restart with 4660.
        rst = 1'b1;
        read_in = 16'h13b0;
        step();
        rst = 1'b0;
        repeat (100) step();
        check("abort_busy", write_out, 16'h0000);
        rst = 1'b1;
        step();
        check("abort_out", write_out, 16'h0000);
        check_done("abort_done", 1'b0);
        read_in = 16'h1234;
        rst = 1'b0;
        wait_result(40000, cyc);
        check("restart_result", write_out, 16'h0003);

        // Long reset holds everything cleared; release then shows fresh latency.
        rst = 1'b1;
        read_in = 16'h0001;
        repeat (30) step();
        check("long_rst_out", write_out, 16'h0000);
        check_done("long_rst_done", 1'b0);
        rst = 1'b0;
        repeat (4) step();
        check("long_rst_before", write_out, 16'h0000);
        step();
        check("long_rst_result", write_out, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
